// File: rtl/c_multi_hot_select_pkg.sv
// c_multi_hot_select shared helpers.
// Provides clogb for the selector and its rotator.
package c_multi_hot_select_pkg;

  function automatic int clogb(input int value);
    int v;
    clogb = 0;
    for (v = value - 1; v > 0; v = v >> 1) begin
      clogb++;
    end
  endfunction

endpackage

// File: rtl/c_rotator.sv
// c_rotator: barrel rotate of a [0:width-1] vector.
// right_i=0 rotates left (out[i]=in[i+amt]), 1 rotates right.
module c_rotator
  import c_multi_hot_select_pkg::*;
#(
  parameter int width = 8,
  localparam int amt_width = clogb(width)
) (
  input  logic [0:width-1]     data_i,
  input  logic [amt_width-1:0] amount_i,
  input  logic                 right_i,
  output logic [0:width-1]     data_o
);

  // log2 stages, each rotating by a power of two mod width
  always_comb begin
    logic [0:width-1] v;
    logic [0:width-1] t;
    int sh;
    v = data_i;
    t = data_i;
    sh = 0;
    for (int s = 0; s < amt_width; s++) begin
      sh = (1 << s) % width;
      for (int i = 0; i < width; i++) begin
        if (right_i) begin
          t[i] = v[(i - sh + width) % width];
        end else begin
          t[i] = v[(i + sh) % width];
        end
      end
      if (amount_i[s]) begin
        v = t;
      end
    end
    data_o = v;
  end

endmodule

// File: rtl/c_multi_hot_select.sv
// c_multi_hot_select: registered N-grant selector.
// Define C_MULTI_HOT_SELECT_RR_EN for a round-robin pointer.
module c_multi_hot_select
  import c_multi_hot_select_pkg::*;
#(
  parameter int width = 8,
  parameter int num_grants = 2,
  localparam int cnt_width = clogb(num_grants + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:width-1]     req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:width-1]     grant,
  output logic [cnt_width-1:0] grant_count
);

  localparam int ptr_width = clogb(width);

  logic                 accept;
  logic [ptr_width-1:0] ptr;
  logic [0:width-1]     rot_req;
  logic [0:width-1]     sel_rot;
  logic [0:width-1]     sel;
  logic [cnt_width-1:0] cnt_d;

  logic                 out_valid_q;
  logic [0:width-1]     grant_q;
  logic [cnt_width-1:0] count_q;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef C_MULTI_HOT_SELECT_RR_EN
  localparam logic [ptr_width:0] width_w =
    (ptr_width + 1)'(width);

  logic [ptr_width-1:0] ptr_q;
  logic [ptr_width-1:0] ptr_d;
  logic [ptr_width-1:0] last;
  logic [ptr_width:0]   sum_w;
  logic [ptr_width:0]   wrap_w;

  assign ptr = ptr_q;

  // highest granted index in the rotated frame
  always_comb begin
    last = '0;
    for (int i = 0; i < width; i++) begin
      if (sel_rot[i]) begin
        last = ptr_width'(i);
      end
    end
  end

  assign sum_w  = {1'b0, ptr_q} + {1'b0, last}
                + (ptr_width + 1)'(1);
  assign wrap_w = (sum_w >= width_w) ?
                  sum_w - width_w : sum_w;
  assign ptr_d  = wrap_w[ptr_width-1:0];

  // advance past the last winner; empty picks hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (accept && (|sel_rot)) begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr = '0;
`endif

  c_rotator #(
    .width (width)
  ) u_rot_in (
    .data_i   (req),
    .amount_i (ptr),
    .right_i  (1'b0),
    .data_o   (rot_req)
  );

  for (genvar k = 0; k < num_grants; k++) begin : g_peel
    logic [0:width-1] rem_in;
    logic [0:width-1] first;
    logic [0:width-1] rem_out;

    if (k == 0) begin : g_head
      assign rem_in = rot_req;
    end else begin : g_link
      assign rem_in = g_peel[k-1].rem_out;
    end

    // isolate the first remaining set bit
    always_comb begin
      logic seen;
      seen  = 1'b0;
      first = '0;
      for (int i = 0; i < width; i++) begin
        first[i] = rem_in[i] & ~seen;
        seen     = seen | rem_in[i];
      end
    end

    assign rem_out = rem_in & ~first;
  end

  assign sel_rot = rot_req & ~g_peel[num_grants-1].rem_out;

  c_rotator #(
    .width (width)
  ) u_rot_out (
    .data_i   (sel_rot),
    .amount_i (ptr),
    .right_i  (1'b1),
    .data_o   (sel)
  );

  // popcount of the selection
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < width; i++) begin
      cnt_d = cnt_d + cnt_width'(sel_rot[i]);
    end
  end

  // output register: load on accept, drain on pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      count_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      grant_q     <= sel;
      count_q     <= cnt_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign grant       = grant_q;
  assign grant_count = count_q;

endmodule

// File: tb/tb_c_multi_hot_select.sv
// Directed bench for c_multi_hot_select.
// Expectations follow C_MULTI_HOT_SELECT_RR_EN when defined.
module tb_c_multi_hot_select;

`ifdef C_MULTI_HOT_SELECT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] req;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] grant;
  logic [1:0] grant_count;

  logic       b_valid;
  logic       b_in_ready;
  logic [0:7] b_req;
  logic       b_out_valid;
  logic       b_ready;
  logic [0:7] b_grant;
  logic [3:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_multi_hot_select #(
    .width      (8),
    .num_grants (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .req         (req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_count (grant_count)
  );

  c_multi_hot_select #(
    .width      (8),
    .num_grants (8)
  ) dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (b_valid),
    .in_ready    (b_in_ready),
    .req         (b_req),
    .out_valid   (b_out_valid),
    .out_ready   (b_ready),
    .grant       (b_grant),
    .grant_count (b_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] rr_seq [4];
    rr_seq = '{8'h48, 8'h42, 8'h0a, 8'h48};
    in_valid  = 1'b0;
    out_ready = 1'b1;
    req       = 8'h00;
    b_valid   = 1'b0;
    b_ready   = 1'b1;
    b_req     = 8'h00;

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_count", grant_count, 0);
    check("rst_ready", in_ready, 1);
    #10 reset_n = 1'b1;
    tick();
    check("idle_ready", in_ready, 1);

    in_valid = 1'b1;
    req      = 8'h4a;
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_grant", grant, 8'h48);
    check("t1_count", grant_count, 2);
    tick();
    check("t2_grant", grant, RR ? 8'h42 : 8'h48);
    check("t2_count", grant_count, 2);

    req = 8'h02;
    tick();
    check("t3_grant", grant, 8'h02);
    check("t3_count", grant_count, 1);
    req = 8'h81;
    tick();
    check("wrap_grant", grant, 8'h81);
    check("wrap_count", grant_count, 2);
    req = 8'h10;
    tick();
    check("single_grant", grant, 8'h10);
    check("single_count", grant_count, 1);

    out_ready = 1'b0;
    req       = 8'h4a;
    #1;
    check("bp_ready0", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_grant", grant, 8'h10);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    tick();
    check("bp_next", grant, RR ? 8'h0a : 8'h48);
    check("bp_nvalid", out_valid, 1);

    in_valid = 1'b0;
    tick();
    check("pop_valid", out_valid, 0);
    check("pop_ready", in_ready, 1);

    in_valid = 1'b1;
    req      = 8'h00;
    tick();
    check("zero_valid", out_valid, 1);
    check("zero_grant", grant, 0);
    check("zero_count", grant_count, 0);
    req = 8'h83;
    tick();
    check("hold_ptr", grant, RR ? 8'h81 : 8'h82);
    check("hold_cnt", grant_count, 2);

    req = 8'h4a;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("seq_grant", grant, RR ? rr_seq[k] : 8'h48);
      check("seq_count", grant_count, 2);
    end

    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_grant", grant, 0);
    check("arst_count", grant_count, 0);
    check("arst_ready", in_ready, 1);
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    req       = 8'h4a;
    tick();
    check("post_rst_grant", grant, 8'h48);
    check("post_rst_valid", out_valid, 1);

    in_valid = 1'b0;
    b_valid  = 1'b1;
    b_req    = 8'hff;
    tick();
    check("n8_grant", b_grant, 8'hff);
    check("n8_count", b_count, 8);
    b_req = 8'h4a;
    tick();
    check("n8_few_grant", b_grant, 8'h4a);
    check("n8_few_count", b_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
